// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC register and the F/D pipeline latch,
// applying branch/jump squash and hazard stalls ahead of decode.
module fetch_stage #(
    parameter int          ADDR_W = 12,
    parameter logic [31:0] NOP    = 32'h0000_0000,
    parameter int          CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       next_pc,
    input  logic              branch_or_jump_pc,
    input  logic              stall,
    input  logic [31:0]       imem_q,
    output logic [31:0]       pc,
    output logic [ADDR_W-1:0] address_imem,
    output logic [31:0]       fd_pc,
    output logic [31:0]       fd_ir,
    output logic              fd_valid,
    output logic              dx_flush,
    output logic [CNT_W-1:0]  flush_count,
    output logic [1:0]        fsm_state
);

    // Encoding is visible on fsm_state: BOOT=0, RUN=1, SQUASH=2.
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t state;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Handshake: there is no valid/ready pair here. A redirect is taken on
    // any edge where branch_or_jump_pc=1 and overrides stall; otherwise
    // stall=1 freezes PC and F/D, and stall=0 lets the pipe advance.

    assign address_imem = pc[ADDR_W-1:0];
    assign dx_flush     = branch_or_jump_pc;
    assign fsm_state    = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= 32'h0;
            fd_pc       <= 32'h0;
            fd_ir       <= NOP;
            fd_valid    <= 1'b0;
            flush_count <= '0;
            state       <= BOOT;
        end else if (branch_or_jump_pc) begin
            pc       <= next_pc;
            fd_pc    <= 32'h0;
            fd_ir    <= NOP;
            fd_valid <= 1'b0;
            state    <= SQUASH;
            if (flush_count != CNT_MAX) begin
                flush_count <= flush_count + 1'b1;
            end
        end else if (!stall) begin
            fd_pc    <= pc;
            fd_ir    <= imem_q;
            fd_valid <= 1'b1;
            pc       <= next_pc;
            case (state)
                BOOT:    state <= RUN;
                RUN:     state <= RUN;
                SQUASH:  state <= RUN;
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed steps plus randomized traffic, each edge
// compared against a rule-level reference model of the fetch pipeline.
module tb_fetch_stage;

    localparam int          ADDR_W = 12;
    localparam int          CNT_W  = 16;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam int          S_BOOT = 0, S_RUN = 1, S_SQUASH = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [31:0]       next_pc;
    logic              branch_or_jump_pc;
    logic              stall;
    logic [31:0]       imem_q;
    logic [31:0]       pc;
    logic [ADDR_W-1:0] address_imem;
    logic [31:0]       fd_pc;
    logic [31:0]       fd_ir;
    logic              fd_valid;
    logic              dx_flush;
    logic [CNT_W-1:0]  flush_count;
    logic [1:0]        fsm_state;

    int errors = 0;
    int checks = 0;

    // Instruction memory: word at address a is mem_base + a.
    logic [31:0] mem_base = 32'h1000_0000;

    // Reference model state
    logic [31:0]      m_pc;
    logic [31:0]      m_fd_pc;
    logic [31:0]      m_fd_ir;
    logic             m_fd_valid;
    logic [CNT_W-1:0] m_cnt;
    int               m_state;

    fetch_stage #(.ADDR_W(ADDR_W), .NOP(NOP), .CNT_W(CNT_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .next_pc           (next_pc),
        .branch_or_jump_pc (branch_or_jump_pc),
        .stall             (stall),
        .imem_q            (imem_q),
        .pc                (pc),
        .address_imem      (address_imem),
        .fd_pc             (fd_pc),
        .fd_ir             (fd_ir),
        .fd_valid          (fd_valid),
        .dx_flush          (dx_flush),
        .flush_count       (flush_count),
        .fsm_state         (fsm_state)
    );

    always #5 clock = ~clock;

    always_comb imem_q = mem_base + {20'h0, address_imem};

    function automatic logic [31:0] mem_word(input logic [31:0] p);
        return mem_base + {20'h0, p[ADDR_W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".pc"},          pc, m_pc);
        check({ctx, ".address"},     {20'h0, address_imem}, {20'h0, m_pc[ADDR_W-1:0]});
        check({ctx, ".fd_pc"},       fd_pc, m_fd_pc);
        check({ctx, ".fd_ir"},       fd_ir, m_fd_ir);
        check({ctx, ".fd_valid"},    {31'h0, fd_valid}, {31'h0, m_fd_valid});
        check({ctx, ".flush_count"}, {16'h0, flush_count}, {16'h0, m_cnt});
        check({ctx, ".state"},       {30'h0, fsm_state}, m_state);
    endtask

    task automatic model_reset();
        m_pc       = 32'h0;
        m_fd_pc    = 32'h0;
        m_fd_ir    = NOP;
        m_fd_valid = 1'b0;
        m_cnt      = '0;
        m_state    = S_BOOT;
    endtask

    // One clock edge: drive inputs, check the combinational flush, advance the
    // model by the priority rules, then compare after the edge.
    task automatic step(input logic br, input logic st, input logic [31:0] npc,
                        input bit do_check, input string ctx);
        branch_or_jump_pc = br;
        stall             = st;
        next_pc           = npc;
        #1;
        if (do_check) check({ctx, ".dx_flush"}, {31'h0, dx_flush}, {31'h0, br});
        if (br) begin
            m_pc       = npc;
            m_fd_pc    = 32'h0;
            m_fd_ir    = NOP;
            m_fd_valid = 1'b0;
            m_state    = S_SQUASH;
            if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        end else if (!st) begin
            m_fd_pc    = m_pc;
            m_fd_ir    = mem_word(m_pc);
            m_fd_valid = 1'b1;
            m_pc       = npc;
            m_state    = S_RUN;
        end
        @(posedge clock);
        #1;
        if (do_check) check_all(ctx);
    endtask

    task automatic apply_reset();
        reset             = 1'b1;
        branch_or_jump_pc = 1'b0;
        stall             = 1'b0;
        next_pc           = 32'h0;
        model_reset();
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset             = 1'b1;
        branch_or_jump_pc = 1'b0;
        stall             = 1'b0;
        next_pc           = 32'h0;

        // Reset state
        apply_reset();
        check_all("reset");

        // Sequential fetch from 0
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, m_pc + 1, 1'b1, "seq");
        check("seq.fd_pc3", fd_pc, 32'h3);
        check("seq.fd_ir3", fd_ir, 32'h1000_0003);

        // Stall held three cycles at pc=5
        step(1'b0, 1'b0, m_pc + 1, 1'b1, "to5");
        check("stall.pc_is_5", pc, 32'h5);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hDEAD_0000, 1'b1, "stall");
        step(1'b0, 1'b0, m_pc + 1, 1'b1, "release");
        check("release.fd_pc", fd_pc, 32'h5);

        // Redirect at pc=8 to 0x40
        while (m_pc != 32'h8) step(1'b0, 1'b0, m_pc + 1, 1'b1, "to8");
        step(1'b1, 1'b0, 32'h40, 1'b1, "redir");
        check("redir.count", {16'h0, flush_count}, 32'h1);
        step(1'b0, 1'b0, m_pc + 1, 1'b1, "after_redir");
        check("after_redir.fd_pc", fd_pc, 32'h40);

        // Redirect concurrent with stall
        step(1'b1, 1'b1, 32'h100, 1'b1, "redir_stall");
        check("redir_stall.pc", pc, 32'h100);

        // Two consecutive redirects
        step(1'b1, 1'b0, 32'h40, 1'b1, "b2b_1");
        step(1'b1, 1'b0, 32'h80, 1'b1, "b2b_2");
        check("b2b.pc", pc, 32'h80);
        step(1'b0, 1'b0, m_pc + 1, 1'b1, "b2b_after");

        // PC near top of address space, no wrap handling
        step(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, "top");
        step(1'b0, 1'b0, 32'h1234_5678, 1'b1, "top_adv");

        // Randomized traffic
        mem_base = $urandom;
        for (int i = 0; i < 300; i++) begin
            logic        br;
            logic        st;
            logic [31:0] npc;
            br  = ($urandom_range(0, 4) == 0);
            st  = ($urandom_range(0, 3) == 0);
            npc = br ? $urandom : (($urandom_range(0, 9) == 0) ? $urandom : m_pc + 1);
            step(br, st, npc, 1'b1, "rand");
        end

        // Asynchronous reset between edges
        stall = 1'b1;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clock);
        reset = 1'b0;
        stall = 1'b0;
        #1;
        check_all("post_rst");
        step(1'b0, 1'b0, 32'h1, 1'b1, "boot_adv");

        // Saturation of flush_count
        apply_reset();
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            step(1'b1, 1'b0, i, (i >= (1 << CNT_W) - 2), "sat");
        end
        check("sat.final", {16'h0, flush_count}, 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
